// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue path: command encodings, legality check
// and the fixed registered latency of the downstream ALU.
package alu_pkg;

    typedef enum logic [3:0] {
        CMD_AND = 4'b0000,
        CMD_OR  = 4'b0001,
        CMD_ADD = 4'b0010,
        CMD_SHL = 4'b0011,
        CMD_SUB = 4'b0100,
        CMD_SHR = 4'b0101,
        CMD_MUL = 4'b0110,
        CMD_XOR = 4'b0111,
        CMD_SLT = 4'b1000
    } alu_cmd_e;

    // Edges from the issue register to the ALU result being capturable.
    localparam int ALU_LATENCY = 2;

    function automatic logic is_legal_cmd(input logic [3:0] cmd);
        return cmd inside {CMD_AND, CMD_OR, CMD_ADD, CMD_SHL, CMD_SUB,
                           CMD_SHR, CMD_MUL, CMD_XOR, CMD_SLT};
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with an extra pointer bit for full/empty; a push into a
// full FIFO is accepted when a pop happens in the same cycle.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   i_push,
    input  logic [WIDTH-1:0]       i_push_data,
    input  logic                   i_pop,
    output logic [WIDTH-1:0]       o_pop_data,
    output logic                   o_empty,
    output logic [$clog2(DEPTH):0] o_count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic             w_full;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_count    = r_wr_ptr - r_rd_ptr;
    assign o_empty    = (r_wr_ptr == r_rd_ptr);
    assign w_full     = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                        (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_do_pop   = i_pop && !o_empty;
    assign w_do_push  = i_push && (!w_full || w_do_pop);
    assign o_pop_data = r_mem[r_rd_ptr[AW-1:0]];

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
        end
    end

    // NOTE: storage is not reset; the pointers alone decide which entries are meaningful.
    always_ff @(posedge clock) begin
        if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_push_data;
    end

endmodule

// File: rtl/alu_issue_queue.sv
// Request buffer and issue stage for the 32-bit ALU: issues at most one op per
// cycle under a response-credit limit and returns results in order with tags.
module alu_issue_queue
    import alu_pkg::*;
#(
    parameter int REQ_DEPTH = 4,
    parameter int RSP_DEPTH = 4,
    parameter int TAG_W     = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [31:0]      req_in1,
    input  logic [31:0]      req_in2,
    input  logic [3:0]       req_cmd,
    input  logic [TAG_W-1:0] req_tag,
    output logic [31:0]      alu_in1,
    output logic [31:0]      alu_in2,
    output logic [3:0]       alu_cmd,
    input  logic [31:0]      alu_result,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [31:0]      rsp_result,
    output logic [TAG_W-1:0] rsp_tag,
    output logic             rsp_err,
    output logic             busy
);
    localparam int RQ_CW  = $clog2(REQ_DEPTH) + 1;
    localparam int RS_CW  = $clog2(RSP_DEPTH) + 1;
    localparam int CRED_W = RS_CW + 2;

    typedef struct packed {
        logic [31:0]      in1;
        logic [31:0]      in2;
        logic [3:0]       cmd;
        logic [TAG_W-1:0] tag;
    } req_t;

    typedef struct packed {
        logic [31:0]      result;
        logic [TAG_W-1:0] tag;
        logic             err;
    } rsp_t;

    typedef struct packed {
        logic             valid;
        logic [TAG_W-1:0] tag;
        logic             err;
    } stage_t;

    req_t                     w_req_in;
    req_t                     w_req_head;
    rsp_t                     w_rsp_in;
    rsp_t                     w_rsp_head;
    logic                     w_req_empty;
    logic                     w_rsp_empty;
    logic [RQ_CW-1:0]         w_req_count;
    logic [RS_CW-1:0]         w_rsp_count;
    logic                     w_req_push;
    logic                     w_head_legal;
    logic                     w_issue;
    logic                     w_pipe_busy;
    logic [CRED_W-1:0]        w_credit_used;
    stage_t [ALU_LATENCY-1:0] r_pipe;
    logic [31:0]              r_alu_in1;
    logic [31:0]              r_alu_in2;
    logic [3:0]               r_alu_cmd;

    assign req_ready    = reset && (w_req_count != RQ_CW'(REQ_DEPTH));
    assign w_req_push   = req_valid && req_ready;
    assign w_req_in     = '{in1: req_in1, in2: req_in2, cmd: req_cmd, tag: req_tag};
    assign w_head_legal = is_legal_cmd(w_req_head.cmd);

    sync_fifo #(.WIDTH($bits(req_t)), .DEPTH(REQ_DEPTH)) u_req_fifo (
        .clock       (clock),
        .reset       (reset),
        .i_push      (w_req_push),
        .i_push_data (w_req_in),
        .i_pop       (w_issue),
        .o_pop_data  (w_req_head),
        .o_empty     (w_req_empty),
        .o_count     (w_req_count)
    );

    // Credits: responses already buffered plus ops still travelling through the ALU.
    // NOTE: every always_comb output gets a default before any conditional logic, so no latch is inferred.
    always_comb begin
        w_credit_used = CRED_W'(w_rsp_count);
        w_pipe_busy   = 1'b0;
        for (int i = 0; i < ALU_LATENCY; i++) begin
            w_credit_used = w_credit_used + CRED_W'(r_pipe[i].valid);
            w_pipe_busy   = w_pipe_busy | r_pipe[i].valid;
        end
        w_issue = !w_req_empty && (w_credit_used < CRED_W'(RSP_DEPTH));
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_pipe    <= '0;
            r_alu_in1 <= '0;
            r_alu_in2 <= '0;
            r_alu_cmd <= '0;
        end else begin
            r_pipe <= {r_pipe[ALU_LATENCY-2:0],
                       stage_t'{valid: w_issue, tag: w_req_head.tag, err: !w_head_legal}};
            // Illegal ops still occupy a pipeline slot but never reach the ALU ports.
            if (w_issue && w_head_legal) begin
                r_alu_in1 <= w_req_head.in1;
                r_alu_in2 <= w_req_head.in2;
                r_alu_cmd <= w_req_head.cmd;
            end
        end
    end

    assign w_rsp_in = '{result: r_pipe[ALU_LATENCY-1].err ? 32'd0 : alu_result,
                        tag:    r_pipe[ALU_LATENCY-1].tag,
                        err:    r_pipe[ALU_LATENCY-1].err};

    sync_fifo #(.WIDTH($bits(rsp_t)), .DEPTH(RSP_DEPTH)) u_rsp_fifo (
        .clock       (clock),
        .reset       (reset),
        .i_push      (r_pipe[ALU_LATENCY-1].valid),
        .i_push_data (w_rsp_in),
        .i_pop       (rsp_ready),
        .o_pop_data  (w_rsp_head),
        .o_empty     (w_rsp_empty),
        .o_count     (w_rsp_count)
    );

    assign alu_in1    = r_alu_in1;
    assign alu_in2    = r_alu_in2;
    assign alu_cmd    = r_alu_cmd;
    assign rsp_valid  = !w_rsp_empty;
    assign rsp_result = w_rsp_head.result;
    assign rsp_tag    = w_rsp_head.tag;
    assign rsp_err    = w_rsp_head.err;
    assign busy       = !w_req_empty || w_pipe_busy || !w_rsp_empty;

endmodule

// File: tb/tb_alu_issue_queue.sv
// Scoreboard bench for alu_issue_queue: a behavioural ALU drives alu_result,
// accepted requests queue their expected response, a monitor pops and compares.
module tb_alu_issue_queue;
    import alu_pkg::*;

    localparam int TAG_W = 4;

    typedef struct packed {
        logic [31:0]      r;
        logic [TAG_W-1:0] t;
        logic             e;
    } exp_t;

    logic             clock = 1'b0;
    logic             reset = 1'b0;
    logic             req_valid;
    logic             req_ready;
    logic [31:0]      req_in1;
    logic [31:0]      req_in2;
    logic [3:0]       req_cmd;
    logic [TAG_W-1:0] req_tag;
    logic [31:0]      alu_in1;
    logic [31:0]      alu_in2;
    logic [3:0]       alu_cmd;
    logic [31:0]      alu_result;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [31:0]      rsp_result;
    logic [TAG_W-1:0] rsp_tag;
    logic             rsp_err;
    logic             busy;

    int   n_checks = 0;
    int   n_err    = 0;
    int   n_acc    = 0;
    int   n_rsp    = 0;
    int   cycle    = 0;
    int   last_acc_cycle = 0;
    int   pop_cycles[$];
    exp_t exp_q[$];
    exp_t got_q[$];
    bit   watch_busy   = 1'b0;
    bit   busy_dropped = 1'b0;
    bit   bad_cmd_seen = 1'b0;
    bit   done4        = 1'b0;
    bit   rnd_on       = 1'b0;

    alu_issue_queue #(.REQ_DEPTH(4), .RSP_DEPTH(4), .TAG_W(TAG_W)) dut (
        .clock      (clock),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_in1    (req_in1),
        .req_in2    (req_in2),
        .req_cmd    (req_cmd),
        .req_tag    (req_tag),
        .alu_in1    (alu_in1),
        .alu_in2    (alu_in2),
        .alu_cmd    (alu_cmd),
        .alu_result (alu_result),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_result (rsp_result),
        .rsp_tag    (rsp_tag),
        .rsp_err    (rsp_err),
        .busy       (busy)
    );

    always #5 clock = ~clock;

    // Reference semantics of each command; illegal encodings yield 0.
    function automatic logic [31:0] ref_result(input logic [31:0] a, input logic [31:0] b,
                                               input logic [3:0] c);
        case (c)
            4'h0:    return a & b;
            4'h1:    return a | b;
            4'h2:    return a + b;
            4'h3:    return a << b[4:0];
            4'h4:    return a - b;
            4'h5:    return a >> b[4:0];
            4'h6:    return a * b;
            4'h7:    return a ^ b;
            4'h8:    return (a < b) ? 32'd1 : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic ref_legal(input logic [3:0] c);
        return c <= 4'h8;
    endfunction

    // Behavioural ALU with one registered stage.
    always @(posedge clock) begin
        alu_result <= ref_result(alu_in1, alu_in2, alu_cmd);
        cycle      <= cycle + 1;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: compares every response transfer against the scoreboard head.
    always @(negedge clock) begin
        if (reset && rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_rsp", {rsp_result, rsp_tag, rsp_err}, 64'd0);
            end else begin
                check("rsp", {rsp_result, rsp_tag, rsp_err}, exp_q.pop_front());
            end
            got_q.push_back({rsp_result, rsp_tag, rsp_err});
            pop_cycles.push_back(cycle);
            n_rsp <= n_rsp + 1;
        end
        if (reset && alu_cmd > 4'h8) bad_cmd_seen <= 1'b1;
        if (watch_busy && !busy)     busy_dropped <= 1'b1;
    end

    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [3:0] c,
                        input logic [TAG_W-1:0] t);
        int waited = 0;
        req_valid = 1'b1;
        req_in1   = a;
        req_in2   = b;
        req_cmd   = c;
        req_tag   = t;
        @(negedge clock);
        while (!req_ready && waited < 500) begin
            @(negedge clock);
            waited++;
        end
        if (!req_ready) begin
            check("req_accept_timeout", {63'd0, req_ready}, 64'd1);
            req_valid = 1'b0;
            return;
        end
        exp_q.push_back('{r: ref_result(a, b, c), t: t, e: !ref_legal(c)});
        n_acc++;
        @(posedge clock);
        #1;
        last_acc_cycle = cycle;
        req_valid      = 1'b0;
    endtask

    task automatic drain(input string name, input int n_exp, input int base);
        int w = 0;
        while (exp_q.size() != 0 && w < 300) begin
            @(posedge clock);
            w++;
        end
        repeat (3) @(posedge clock);
        #1;
        check({name, "_drained"}, 64'(exp_q.size()), 64'd0);
        check({name, "_count"}, 64'(n_rsp - base), 64'(n_exp));
    endtask

    initial begin
        int base;
        int pc;
        int a;
        req_valid = 1'b0;
        req_in1   = '0;
        req_in2   = '0;
        req_cmd   = '0;
        req_tag   = '0;
        rsp_ready = 1'b0;

        // Reset state
        repeat (3) @(posedge clock);
        @(negedge clock);
        check("reset_flags", {61'd0, req_ready, rsp_valid, busy}, 64'd0);
        check("reset_alu_ops", {alu_in1, alu_in2}, 64'd0);
        check("reset_alu_cmd", {60'd0, alu_cmd}, 64'd0);
        @(posedge clock);
        #1 reset = 1'b1;

        // Single ADD with latency check
        rsp_ready = 1'b1;
        base = n_rsp;
        send(32'd5, 32'd7, CMD_ADD, 4'd3);
        a = last_acc_cycle;
        @(posedge clock);
        @(posedge clock);
        @(negedge clock);
        check("lat_early", {63'd0, rsp_valid}, 64'd0);
        @(negedge clock);
        check("lat_on_time", {63'd0, rsp_valid}, 64'd1);
        check("lat_edge", 64'(cycle - a), 64'd3);
        drain("add", 1, base);
        check("add_value", 64'(got_q[base]), 64'({32'd12, 4'd3, 1'b0}));

        // Back-to-back SUB/SLT/MUL
        base = n_rsp;
        pc   = pop_cycles.size();
        send(32'd10, 32'd3, CMD_SUB, 4'd0);
        send(32'd2,  32'd9, CMD_SLT, 4'd1);
        send(32'd6,  32'd7, CMD_MUL, 4'd2);
        drain("b2b", 3, base);
        check("b2b_0", 64'(got_q[base]),   64'({32'd7,  4'd0, 1'b0}));
        check("b2b_1", 64'(got_q[base+1]), 64'({32'd1,  4'd1, 1'b0}));
        check("b2b_2", 64'(got_q[base+2]), 64'({32'd42, 4'd2, 1'b0}));
        check("b2b_consecutive", 64'(pop_cycles[pc+2] - pop_cycles[pc]), 64'd2);

        // Illegal command between two ORs
        base = n_rsp;
        send(32'hF0, 32'h0F, CMD_OR, 4'd4);
        send(32'd1,  32'd1,  4'hF,   4'd5);
        send(32'd1,  32'd2,  CMD_OR, 4'd6);
        drain("illegal", 3, base);
        check("illegal_0", 64'(got_q[base]),   64'({32'hFF, 4'd4, 1'b0}));
        check("illegal_1", 64'(got_q[base+1]), 64'({32'h0,  4'd5, 1'b1}));
        check("illegal_2", 64'(got_q[base+2]), 64'({32'h3,  4'd6, 1'b0}));
        check("alu_cmd_never_illegal", {63'd0, bad_cmd_seen}, 64'd0);

        // Backpressure: 4 + 4 held, remaining 2 accepted after release
        rsp_ready = 1'b0;
        base = n_rsp;
        a    = n_acc;
        fork
            begin
                for (int i = 0; i < 10; i++)
                    send(32'(i * 3), 32'(i + 1), CMD_ADD, TAG_W'(i));
                done4 = 1'b1;
            end
        join_none
        repeat (5) @(posedge clock);
        watch_busy = 1'b1;
        repeat (35) @(posedge clock);
        @(negedge clock);
        watch_busy = 1'b0;
        check("full_accepted", 64'(n_acc - a), 64'd8);
        check("full_req_ready", {63'd0, req_ready}, 64'd0);
        check("full_busy_held", {63'd0, busy_dropped}, 64'd0);
        rsp_ready = 1'b1;
        for (int w = 0; w < 500 && !done4; w++) @(posedge clock);
        check("full_sender_done", {63'd0, done4}, 64'd1);
        drain("full", 10, base);

        // Reset with three requests in flight
        rsp_ready = 1'b0;
        send(32'h11, 32'h22, CMD_XOR, 4'd1);
        send(32'h33, 32'h44, CMD_AND, 4'd2);
        send(32'h55, 32'h66, CMD_ADD, 4'd3);
        reset = 1'b0;
        @(negedge clock);
        check("req_ready_in_reset", {63'd0, req_ready}, 64'd0);
        @(posedge clock);
        #1;
        reset = 1'b1;
        exp_q.delete();
        check("post_reset_idle", {62'd0, rsp_valid, busy}, 64'd0);
        rsp_ready = 1'b1;
        base = n_rsp;
        send(32'hFF00, 32'h0FF0, CMD_XOR, 4'd9);
        drain("post_reset", 1, base);
        check("post_reset_value", 64'(got_q[base]), 64'({32'hF0F0, 4'd9, 1'b0}));

        // Randomized traffic with random response backpressure
        rnd_on = 1'b1;
        fork
            while (rnd_on) begin
                @(posedge clock);
                #1;
                rsp_ready = ($urandom_range(0, 3) != 0);
            end
        join_none
        base = n_rsp;
        for (int i = 0; i < 60; i++) begin
            logic [3:0] c;
            c = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(9, 15)) : 4'($urandom_range(0, 8));
            repeat ($urandom_range(0, 2)) begin
                @(posedge clock);
                #1;
            end
            send($urandom, $urandom, c, TAG_W'($urandom_range(0, 15)));
        end
        rnd_on = 1'b0;
        @(posedge clock);
        #2;
        rsp_ready = 1'b1;
        drain("random", 60, base);
        check("random_alu_cmd_never_illegal", {63'd0, bad_cmd_seen}, 64'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected completion");
        $display("Result: errors=%0d of %0d checks", n_err + 1, n_checks + 1);
        $fatal(1, "watchdog expired");
    end

endmodule
